// File: rtl/adder_pkg.sv
// Shared op encodings and width helpers for the pipelined flexible adder.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int max_width(input int wa, input int wb);
        return (wa > wb) ? wa : wb;
    endfunction

    function automatic int seg_width(input int wi, input int stages);
        return (wi + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One registered slice of the carry chain: sum slice plus carry out, held when en is low.
module adder_segment
    import adder_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W:0] sum_d;
    logic [W:0] sum_q;

    assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

    assign s_o = sum_q[W-1:0];
    assign c_o = sum_q[W];

endmodule

// File: rtl/adder_pipelined_flexible.sv
// Add/subtract with the carry chain split across STAGES register stages and valid/ready flow.
// Define ADDER_PIPELINED_SAT_EN to clamp the result on overflow instead of wrapping.
module adder_pipelined_flexible
    import adder_pkg::*;
#(
    parameter int WIDTH_A   = 8,
    parameter int WIDTH_B   = 8,
    parameter int SIGNED    = 0,
    parameter int STAGES    = 2,
    parameter int WIDTH_OUT = 1 + max_width(WIDTH_A, WIDTH_B)
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_A-1:0]   a,
    input  logic [WIDTH_B-1:0]   b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] result,
    output logic                 ovf
);

    localparam int WI  = 1 + max_width(WIDTH_A, WIDTH_B);
    localparam int SEG = seg_width(WI, STAGES);
    // Chain is padded to a whole number of segments; bits above WI are discarded.
    localparam int WP  = SEG * STAGES;

    logic [WP-1:0] a_ext, b_ext, b_eff;

    if (SIGNED != 0) begin : g_sext
        assign a_ext = {{(WP-WIDTH_A){a[WIDTH_A-1]}}, a};
        assign b_ext = {{(WP-WIDTH_B){b[WIDTH_B-1]}}, b};
    end else begin : g_zext
        assign a_ext = {{(WP-WIDTH_A){1'b0}}, a};
        assign b_ext = {{(WP-WIDTH_B){1'b0}}, b};
    end

    assign b_eff = (op == OP_ADD) ? b_ext : ~b_ext;

    logic              advance;
    logic [STAGES-1:0] valid_d, valid_q;
    logic [WP-1:0]     opa_d [STAGES];
    logic [WP-1:0]     opb_d [STAGES];
    logic [WP-1:0]     low_d [STAGES];
    logic              cin_d [STAGES];
    logic [WP-1:0]     opa_q [STAGES];
    logic [WP-1:0]     opb_q [STAGES];
    logic [WP-1:0]     low_q [STAGES];
    logic [SEG-1:0]    sum_q [STAGES];
    logic              cout_q[STAGES];
    logic [WP-1:0]     res_w [STAGES];

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];

    always_comb begin
        valid_d[0] = in_valid;
        opa_d[0]   = a_ext;
        opb_d[0]   = b_eff;
        low_d[0]   = '0;
        cin_d[0]   = (op == OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            opa_d[k]   = opa_q[k-1];
            opb_d[k]   = opb_q[k-1];
            low_d[k]   = res_w[k-1];
            cin_d[k]   = cout_q[k-1];
        end
    end

    // res_w[k]: finished low segments carried along with the slice computed in stage k.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res_w[k] = low_q[k];
            res_w[k][k*SEG +: SEG] = sum_q[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(.W(SEG)) u_seg (
            .clk   (clk),
            .clr_n (RST),
            .en    (advance),
            .a_i   (opa_d[k][k*SEG +: SEG]),
            .b_i   (opb_d[k][k*SEG +: SEG]),
            .c_i   (cin_d[k]),
            .s_o   (sum_q[k]),
            .c_o   (cout_q[k])
        );
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                low_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                low_q[k] <= low_d[k];
            end
        end
    end

    logic [WI-1:0] full_w;
    logic          ovf_w;

    assign full_w = res_w[STAGES-1][WI-1:0];

    if (WIDTH_OUT >= WI) begin : g_exact
        assign ovf_w = 1'b0;
    end else if (SIGNED != 0) begin : g_sovf
        assign ovf_w = !((&full_w[WI-1:WIDTH_OUT-1]) || !(|full_w[WI-1:WIDTH_OUT-1]));
    end else begin : g_uovf
        assign ovf_w = |full_w[WI-1:WIDTH_OUT];
    end

    assign ovf = ovf_w;

`ifdef ADDER_PIPELINED_SAT_EN
    always_comb begin
        result = full_w[WIDTH_OUT-1:0];
        if (ovf_w) begin
            result = '1;
            if (SIGNED != 0) begin
                // Negative overflow -> 100..0, positive -> 011..1.
                result = {WIDTH_OUT{~full_w[WI-1]}};
                result[WIDTH_OUT-1] = full_w[WI-1];
            end
        end
    end
`else
    assign result = full_w[WIDTH_OUT-1:0];
`endif

endmodule

// File: tb/tb_adder_pipelined_flexible.sv
// Scoreboard bench exercising four adder configurations in parallel against an arithmetic model.
module tb_adder_pipelined_flexible;

    localparam int NCFG = 4;

`ifdef ADDER_PIPELINED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [NCFG-1:0] done;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int WA = (g == 3) ? 6 : 8;
        localparam int WB = (g == 3) ? 4 : 8;
        localparam int SG = (g == 1 || g == 3) ? 1 : 0;
        localparam int WI = 1 + ((WA > WB) ? WA : WB);
        localparam int ST = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 1 : WI;
        localparam int WO = (g == 2) ? 8 : (g == 3) ? 5 : WI;
        // Directed operation per configuration with hand-computed answer.
        localparam longint DA   = (g == 0) ? 255 : (g == 1) ? 128 : (g == 2) ? 200 : 31;
        localparam longint DB   = (g == 0) ? 255 : (g == 1) ? 1 : (g == 2) ? 100 : 8;
        localparam bit     DOP  = (g == 1 || g == 3);
        localparam longint DRES = (g == 0) ? 510 : (g == 1) ? 383 :
                                  (g == 2) ? (SAT ? 255 : 44) : (SAT ? 15 : 7);
        localparam bit     DOVF = (g >= 2);

        logic          rst_n, in_valid, in_ready, op, out_valid, out_ready, ovf;
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        logic [WO-1:0] result;
        longint        exp_res_q[$];
        bit            exp_ovf_q[$];
        longint        cur_res;
        bit            cur_ovf;
        bit            done_g = 1'b0;

        assign done[g] = done_g;

        adder_pipelined_flexible #(
            .WIDTH_A(WA), .WIDTH_B(WB), .SIGNED(SG), .STAGES(ST), .WIDTH_OUT(WO)
        ) u_dut (
            .clk(clk), .RST(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
            .result(result), .ovf(ovf)
        );

        function automatic string tag(input string s);
            return $sformatf("cfg%0d_%s", g, s);
        endfunction

        function automatic longint sx(input longint v, input int w);
            if (SG != 0 && v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
            return v;
        endfunction

        function automatic void model(input longint av, input longint bv, input bit opv,
                                      output longint r, output bit o);
            longint x, y, full, mo, hw, u;
            x    = sx(av, WA);
            y    = sx(bv, WB);
            full = opv ? x - y : x + y;
            mo   = longint'(1) << WO;
            hw   = longint'(1) << WI;
            if (SG != 0) begin
                o = (full > mo / 2 - 1) || (full < -(mo / 2));
            end else begin
                u = ((full % hw) + hw) % hw;
                o = (u >= mo);
            end
            r = ((full % mo) + mo) % mo;
            if (SAT && o) r = (SG == 0) ? mo - 1 : (full < 0) ? mo / 2 : mo / 2 - 1;
        endfunction

        function automatic longint rnd(input int w);
            int unsigned r;
            r = $urandom % 8;
            if (r == 0) return 0;
            if (r == 1) return (longint'(1) << w) - 1;
            if (r == 2) return longint'(1) << (w - 1);
            return longint'($urandom) & ((longint'(1) << w) - 1);
        endfunction

        task automatic drive_rand();
            longint av, bv;
            bit     opv;
            av  = rnd(WA);
            bv  = rnd(WB);
            opv = 1'($urandom % 2);
            a   = WA'(av);
            b   = WB'(bv);
            op  = opv;
            model(av, bv, opv, cur_res, cur_ovf);
        endtask

        task automatic step(output bit acc);
            @(negedge clk);
            acc = in_valid && in_ready && rst_n;
            if (acc) begin
                exp_res_q.push_back(cur_res);
                exp_ovf_q.push_back(cur_ovf);
            end
            @(posedge clk);
            #1;
        endtask

        task automatic time_one(input string nm);
            bit acc;
            int n;
            in_valid = 1'b1;
            step(acc);
            in_valid = 1'b0;
            check(tag({nm, "_accept"}), acc, 1);
            n = 1;
            while (!out_valid && n < ST + 5) begin
                @(posedge clk);
                #1;
                n++;
            end
            check(tag({nm, "_latency"}), n, ST);
        endtask

        initial begin : drv
            bit acc;
            int sent;
            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            a = '0; b = '0; op = 1'b0; cur_res = 0; cur_ovf = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check(tag("rst_out_valid"), out_valid, 0);
            check(tag("rst_in_ready"), in_ready, 1);
            check(tag("rst_result"), longint'(result), 0);
            check(tag("rst_ovf"), ovf, 0);
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            a = WA'(DA); b = WB'(DB); op = DOP; cur_res = DRES; cur_ovf = DOVF;
            time_one("directed");

            // Back-to-back stream of 10 with downstream stalled in cycles 4..7.
            sent = 0;
            for (int c = 0; c < 80 && !(sent == 10 && exp_res_q.size() == 0 && !out_valid); c++) begin
                out_ready = !(c >= 4 && c <= 7);
                in_valid  = (sent < 10);
                drive_rand();
                #1;
                if (c >= 4 && c <= 7 && c >= ST) check(tag("stall_in_ready"), in_ready, 0);
                step(acc);
                if (acc) sent++;
            end
            check(tag("stream_sent"), sent, 10);
            check(tag("stream_drained"), exp_res_q.size(), 0);

            sent = 0;
            for (int c = 0; c < 3000 && !(sent == 150 && exp_res_q.size() == 0 && !out_valid); c++) begin
                out_ready = ($urandom % 10) < 7;
                in_valid  = (sent < 150) && (($urandom % 4) != 0);
                drive_rand();
                step(acc);
                if (acc) sent++;
            end
            check(tag("random_sent"), sent, 150);
            check(tag("random_drained"), exp_res_q.size(), 0);

            // Reset with two operations in flight.
            out_ready = 1'b1;
            sent = 0;
            for (int c = 0; c < 20 && sent < 2; c++) begin
                in_valid = 1'b1;
                drive_rand();
                step(acc);
                if (acc) sent++;
            end
            in_valid = 1'b0;
            #2;
            rst_n = 1'b0;
            exp_res_q.delete();
            exp_ovf_q.delete();
            #1;
            check(tag("midrst_out_valid"), out_valid, 0);
            check(tag("midrst_in_ready"), in_ready, 1);
            check(tag("midrst_result"), longint'(result), 0);
            check(tag("midrst_ovf"), ovf, 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int c = 0; c < 6; c++) begin
                step(acc);
                check(tag("post_rst_idle"), out_valid, 0);
            end
            drive_rand();
            time_one("post_rst");
            for (int c = 0; c < 50 && exp_res_q.size() != 0; c++) step(acc);
            check(tag("final_drained"), exp_res_q.size(), 0);
            done_g = 1'b1;
        end

        initial begin : mon
            bit            held;
            logic [WO-1:0] hres;
            logic          hovf;
            longint        r;
            bit            o;
            held = 1'b0;
            hres = '0;
            hovf = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    check(tag("in_ready_rule"), in_ready, !out_valid || out_ready);
                    if (held) begin
                        check(tag("hold_valid"), out_valid, 1);
                        check(tag("hold_result"), longint'(result), longint'(hres));
                        check(tag("hold_ovf"), ovf, hovf);
                    end
                    if (out_valid && out_ready) begin
                        if (exp_res_q.size() == 0) begin
                            check(tag("output_with_empty_queue"), exp_res_q.size(), 1);
                        end else begin
                            r = exp_res_q.pop_front();
                            o = exp_ovf_q.pop_front();
                            check(tag("result"), longint'(result), r);
                            check(tag("ovf"), ovf, o);
                        end
                    end
                    held = out_valid && !out_ready;
                    hres = result;
                    hovf = ovf;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : fin
        for (int c = 0; c < 20000 && done !== '1; c++) @(posedge clk);
        check("all_configs_done", done, {NCFG{1'b1}});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
